// File: rtl/spi_ram_ctrl.sv
// SPI command decoder + 8-bit RAM; optional burst addressing via RAM_AUTO_INC_EN.
// Latency: command takes effect on the edge it is accepted; read data/tx_valid valid from that edge.
// Backpressure: none; one command per rising edge of rx_valid, held-high cycles ignored.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       rd_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ADDR_RDY = 2'd1,
        TX       = 2'd2
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    state_t               state;
    state_t               state_nxt;
    logic                 rx_valid_q;
    logic                 accept;
    logic [1:0]           cmd;
    logic [ADDR_SIZE-1:0] addr_in;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 do_read;
    logic                 err_nxt;
    logic                 do_write;
    logic [7:0]           mem [MEM_DEPTH];

    assign accept   = rx_valid && !rx_valid_q;
    assign cmd      = rx_data[9:8];
    assign addr_in  = rx_data[ADDR_SIZE-1:0];
    assign do_write = accept && (cmd == CMD_WR_DATA);
    assign tx_valid = (state == TX);

    always_comb begin
        state_nxt = state;
        do_read   = 1'b0;
        err_nxt   = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (cmd == CMD_RD_ADDR) begin
                        state_nxt = ADDR_RDY;
                    end else if (cmd == CMD_RD_DATA) begin
                        err_nxt = 1'b1;
                    end
                end
                ADDR_RDY: begin
                    if (cmd == CMD_RD_DATA) begin
                        do_read   = 1'b1;
                        state_nxt = TX;
                    end
                end
                TX: begin
                    case (cmd)
                        CMD_RD_ADDR: state_nxt = ADDR_RDY;
                        CMD_RD_DATA: begin
`ifdef RAM_AUTO_INC_EN
                            do_read   = 1'b1;
                            state_nxt = TX;
`else
                            err_nxt   = 1'b1;
                            state_nxt = IDLE;
`endif
                        end
                        default: begin
                            // Address consumed by the read unless bursting keeps it live
`ifdef RAM_AUTO_INC_EN
                            state_nxt = ADDR_RDY;
`else
                            state_nxt = IDLE;
`endif
                        end
                    endcase
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rx_valid_q <= 1'b0;
            rd_err     <= 1'b0;
            tx_data    <= 8'h00;
            wr_addr    <= '0;
            rd_addr    <= '0;
        end else begin
            state      <= state_nxt;
            rx_valid_q <= rx_valid;
            rd_err     <= err_nxt;
            if (do_read) begin
                tx_data <= mem[rd_addr];
            end
            if (accept && (cmd == CMD_WR_ADDR)) begin
                wr_addr <= addr_in;
            end
            if (accept && (cmd == CMD_RD_ADDR)) begin
                rd_addr <= addr_in;
            end
`ifdef RAM_AUTO_INC_EN
            // Width equals log2(MEM_DEPTH), so natural overflow gives the wrap
            if (do_write) begin
                wr_addr <= wr_addr + ADDR_SIZE'(1);
            end
            if (do_read) begin
                rd_addr <= rd_addr + ADDR_SIZE'(1);
            end
`endif
        end
    end

    // RAM contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_addr] <= rx_data[7:0];
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed, table-driven bench for spi_ram_ctrl; expectations track RAM_AUTO_INC_EN.
module tb_spi_ram_ctrl;

    logic       clk;
    logic       rst;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       rd_err;

    int tests;
    int fails;

    logic       s_txv;
    logic [7:0] s_txd;
    logic       s_err;
    logic       s_txv2;
    logic       s_err2;

    typedef struct {
        logic [9:0] d;
        int         hold;
        logic       txv;
        logic [7:0] txd;
        logic       err;
    } vec_t;

    vec_t vt[$];

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .rd_err   (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with rx_valid low for one edge.
    task automatic send(input logic [9:0] d, input int hold);
        rx_data  = d;
        rx_valid = 1'b1;
        @(negedge clk);
        s_txv = tx_valid;
        s_txd = tx_data;
        s_err = rd_err;
        for (int i = 1; i < hold; i++) @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        s_txv2 = tx_valid;
        s_err2 = rd_err;
    endtask

    task automatic add(input logic [9:0] d, input int hold, input logic txv,
                       input logic [7:0] txd, input logic err);
        vec_t v;
        v.d = d; v.hold = hold; v.txv = txv; v.txd = txd; v.err = err;
        vt.push_back(v);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 10'h000;

        // Common prefix: both builds
        add(10'h300, 1, 1'b0, 8'h00, 1'b1);
        add(10'h005, 1, 1'b0, 8'h00, 1'b0);
        add(10'h1A5, 1, 1'b0, 8'h00, 1'b0);
        add(10'h205, 1, 1'b0, 8'h00, 1'b0);
        add(10'h300, 3, 1'b1, 8'hA5, 1'b0);
        add(10'h010, 1, 1'b0, 8'hA5, 1'b0);
        add(10'h1C3, 5, 1'b0, 8'hA5, 1'b0);
        add(10'h1D7, 1, 1'b0, 8'hA5, 1'b0);
        add(10'h210, 1, 1'b0, 8'hA5, 1'b0);
`ifdef RAM_AUTO_INC_EN
        add(10'h300, 1, 1'b1, 8'hC3, 1'b0);
        add(10'h300, 1, 1'b1, 8'hD7, 1'b0);
        add(10'h0FF, 1, 1'b0, 8'hD7, 1'b0);
        add(10'h111, 1, 1'b0, 8'hD7, 1'b0);
        add(10'h122, 1, 1'b0, 8'hD7, 1'b0);
        add(10'h2FF, 1, 1'b0, 8'hD7, 1'b0);
        add(10'h300, 1, 1'b1, 8'h11, 1'b0);
        add(10'h300, 1, 1'b1, 8'h22, 1'b0);
        add(10'h155, 1, 1'b0, 8'h22, 1'b0);
        add(10'h300, 1, 1'b1, 8'h55, 1'b0);
        add(10'h2FF, 1, 1'b0, 8'h55, 1'b0);
        add(10'h300, 1, 1'b1, 8'h11, 1'b0);
`else
        add(10'h300, 1, 1'b1, 8'hD7, 1'b0);
        add(10'h300, 1, 1'b0, 8'hD7, 1'b1);
        add(10'h300, 1, 1'b0, 8'hD7, 1'b1);
        add(10'h0FF, 1, 1'b0, 8'hD7, 1'b0);
        add(10'h111, 1, 1'b0, 8'hD7, 1'b0);
        add(10'h000, 1, 1'b0, 8'hD7, 1'b0);
        add(10'h122, 1, 1'b0, 8'hD7, 1'b0);
        add(10'h2FF, 1, 1'b0, 8'hD7, 1'b0);
        add(10'h300, 1, 1'b1, 8'h11, 1'b0);
        add(10'h200, 1, 1'b0, 8'h11, 1'b0);
        add(10'h300, 1, 1'b1, 8'h22, 1'b0);
        add(10'h033, 1, 1'b0, 8'h22, 1'b0);
        add(10'h300, 1, 1'b0, 8'h22, 1'b1);
`endif

        repeat (3) @(negedge clk);
        check("reset tx_valid", 32'(tx_valid), 32'd0);
        check("reset rd_err", 32'(rd_err), 32'd0);
        check("reset tx_data", 32'(tx_data), 32'h00);
        rst = 1'b0;
        @(negedge clk);

        foreach (vt[i]) begin
            send(vt[i].d, vt[i].hold);
            check($sformatf("v%0d tx_valid", i), 32'(s_txv), 32'(vt[i].txv));
            check($sformatf("v%0d tx_data", i), 32'(s_txd), 32'(vt[i].txd));
            check($sformatf("v%0d rd_err", i), 32'(s_err), 32'(vt[i].err));
            check($sformatf("v%0d rd_err pulse end", i), 32'(s_err2), 32'd0);
            check($sformatf("v%0d tx_valid hold", i), 32'(s_txv2), 32'(vt[i].txv));
        end

        // Reset in the middle of a TX: outputs clear, RAM survives
        send(10'h205, 1);
        send(10'h300, 1);
        check("pre-reset tx_valid", 32'(s_txv), 32'd1);
        check("pre-reset tx_data", 32'(s_txd), 32'hA5);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid reset tx_valid", 32'(tx_valid), 32'd0);
        check("mid reset rd_err", 32'(rd_err), 32'd0);
        check("mid reset tx_data", 32'(tx_data), 32'h00);
        rst = 1'b0;
        @(negedge clk);
        check("post reset tx_valid", 32'(tx_valid), 32'd0);
        send(10'h300, 1);
        check("post reset idle rd_err", 32'(s_err), 32'd1);
        check("post reset idle tx_valid", 32'(s_txv), 32'd0);
        send(10'h205, 1);
        send(10'h300, 1);
        check("ram retained tx_data", 32'(s_txd), 32'hA5);
        check("ram retained tx_valid", 32'(s_txv), 32'd1);

        // wr_addr must have been cleared to 0 by the reset
        send(10'h1EE, 1);
        send(10'h200, 1);
        send(10'h300, 1);
        check("wr_addr reset tx_data", 32'(s_txd), 32'hEE);
        check("wr_addr reset rd_err", 32'(s_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
